// File: rtl/int2float_enc.sv
// int2float_enc: converts an 11-bit unsigned integer into a 7-bit
// floating-point code {exponent[2:0], mantissa[3:0]}, registered with a
// one-cycle latency and a valid flag. Truncates toward zero, never saturates.
module int2float_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [10:0] in0,
    output logic [3:0]  out0,
    output logic [2:0]  out1,
    output logic        out_valid
);

    logic [2:0] exp_d;
    logic [3:0] man_d;
    logic [2:0] exp_q;
    logic [3:0] man_q;
    logic       valid_q;

    // Leading-one detector over in0[10:4]; the highest set bit wins, and values below 16 stay denormal.
    always_comb begin
        exp_d = 3'd0;
        for (int i = 4; i <= 10; i++) begin
            if (in0[i]) begin
                exp_d = 3'(i - 3);
            end
        end
    end

    // Mantissa select: take the four bits directly below the leading one (e=0 and e=1 share in0[3:0]).
    always_comb begin
        man_d = in0[3:0];
        case (exp_d)
            3'd2:    man_d = in0[4:1];
            3'd3:    man_d = in0[5:2];
            3'd4:    man_d = in0[6:3];
            3'd5:    man_d = in0[7:4];
            3'd6:    man_d = in0[8:5];
            3'd7:    man_d = in0[9:6];
            default: man_d = in0[3:0];
        endcase
    end

    // Output register: capture the code on valid input, hold it otherwise; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q   <= 3'd0;
            man_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                exp_q <= exp_d;
                man_q <= man_d;
            end
        end
    end

    assign out0      = man_q;
    assign out1      = exp_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_int2float_enc.sv
// tb_int2float_enc: scoreboard bench for int2float_enc. The driver pushes one
// expected {valid, packed} entry per clock into a queue; the monitor pops and
// compares one entry per clock just after the capturing edge.
module tb_int2float_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in0;
    logic [3:0]  out0;
    logic [2:0]  out1;
    logic        out_valid;

    typedef struct {
        logic       v;
        logic [6:0] p;
    } expect_t;

    expect_t    sbQ[$];
    int         checkCount;
    int         failCount;
    logic [6:0] heldPacked;

    int2float_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in0       (in0),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion: find the power-of-two bucket arithmetically, then
    // take the scaled offset above the implicit leading one.
    function automatic logic [6:0] refConvert(input int x);
        int lead;
        int e;
        if (x < 16) return 7'(x);
        lead = 0;
        while ((1 << (lead + 1)) <= x) lead++;
        e = lead - 3;
        return 7'((e << 4) | ((x >> (e - 1)) - 16));
    endfunction

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one clock's worth of inputs and push what the DUT must show after the next edge.
    // expOverride >= 0 supplies a hand-computed packed code instead of the model's.
    task automatic applyStimulus(input logic r, input logic v, input logic [10:0] d, input int expOverride);
        expect_t e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in0      = d;
        if (!r) begin
            heldPacked = 7'd0;
            e.v = 1'b0;
            e.p = 7'd0;
        end else if (v) begin
            heldPacked = (expOverride >= 0) ? 7'(expOverride) : refConvert(int'(d));
            e.v = 1'b1;
            e.p = heldPacked;
        end else begin
            e.v = 1'b0;
            e.p = heldPacked;
        end
        sbQ.push_back(e);
    endtask

    // Monitor: one scoreboard entry retires per clock, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("out_valid", {7'd0, out_valid}, {7'd0, e.v});
            if (e.v) checkOutput("packed", {1'b0, out1, out0}, {1'b0, e.p});
            else     checkOutput("packed_hold", {1'b0, out1, out0}, {1'b0, e.p});
        end
    end

    initial begin
        int waitCycles;
        checkCount = 0;
        failCount  = 0;
        heldPacked = 7'd0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in0        = 11'd0;

        // Reset held with an active max input: outputs must stay cleared.
        applyStimulus(1'b0, 1'b1, 11'd2047, 0);
        applyStimulus(1'b0, 1'b1, 11'd2047, 0);

        // Denormal / exponent boundaries, truncation and maximum, back to back.
        applyStimulus(1'b1, 1'b1, 11'd0,    0);
        applyStimulus(1'b1, 1'b1, 11'd15,   15);
        applyStimulus(1'b1, 1'b1, 11'd16,   16);
        applyStimulus(1'b1, 1'b1, 11'd31,   31);
        applyStimulus(1'b1, 1'b1, 11'd100,  57);
        applyStimulus(1'b1, 1'b1, 11'd1000, 111);
        applyStimulus(1'b1, 1'b1, 11'd1023, 111);
        applyStimulus(1'b1, 1'b1, 11'd1024, 112);
        applyStimulus(1'b1, 1'b1, 11'd2047, 127);

        // Gap: 500 must not be captured, the 16 result is held, then 64 -> 48.
        applyStimulus(1'b1, 1'b1, 11'd16,  16);
        applyStimulus(1'b1, 1'b0, 11'd500, -1);
        applyStimulus(1'b1, 1'b1, 11'd64,  48);

        // Continuous random stream checked against the reference model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b1, 1'b1, 11'($urandom_range(0, 2047)), -1);
        end

        // Random valid pattern with random idle data that must be ignored.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), -1);
        end

        // Reset in the middle of a stream drops the in-flight result.
        applyStimulus(1'b1, 1'b1, 11'd1500, -1);
        applyStimulus(1'b0, 1'b1, 11'd777,  -1);
        applyStimulus(1'b1, 1'b0, 11'd333,  -1);
        applyStimulus(1'b1, 1'b1, 11'd200,  -1);
        applyStimulus(1'b1, 1'b0, 11'd0,    -1);

        // Let the scoreboard drain, bounded.
        waitCycles = 0;
        while (sbQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (sbQ.size() > 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
